// File: rtl/enc_b2oh_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_b2oh_pkg
// Purpose  : Shared constants and types for the binary-to-one-hot stream
//            encoder: width and saturation limit of the error counter.
// Revision : 1.0 - initial release
// ============================================================================
package enc_b2oh_pkg;

    localparam int ERR_CNT_W = 8;

    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    // The counter stops here instead of wrapping to zero.
    localparam err_cnt_t ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage : enc_b2oh_pkg
`default_nettype wire

// File: rtl/enc_b2oh_skid.sv
`default_nettype none
// ============================================================================
// Module   : enc_b2oh_skid
// Purpose  : Two-entry skid buffer: an output register plus one spare entry.
//            Upstream ready is a pure register output, which removes the
//            combinational path from downstream ready back to upstream ready.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous active-low reset
//            i_valid  - upstream beat valid
//            o_ready  - upstream may present a beat (spare entry empty)
//            i_data   - upstream payload
//            o_valid  - downstream beat valid
//            i_ready  - downstream accepts beat
//            o_data   - downstream payload
// Revision : 1.0 - initial release
// ============================================================================
module enc_b2oh_skid #(
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_accept;
    logic              w_out_free;

    // The spare entry only fills while the output register is stalled, so
    // upstream ready falls only when both entries hold a beat.
    assign o_ready    = ~r_skid_valid;
    assign w_accept   = i_valid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Older beat in the spare entry moves forward first; upstream
                // is held off this cycle, so nothing new arrives.
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= i_data;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule : enc_b2oh_skid
`default_nettype wire

// File: rtl/enc_bin2onehot_stream.sv
`default_nettype none
// ============================================================================
// Module   : enc_bin2onehot_stream
// Purpose  : Valid/ready streaming binary-to-one-hot decoder with registered
//            output (latency 1, one beat per cycle). Codes at or above OUT_W
//            yield an all-zero word with out_err set and are counted in a
//            saturating error counter at acceptance.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-low reset
//            in_valid   - upstream beat valid
//            in_ready   - block can accept a beat
//            in         - binary code, IN_W bits
//            out_valid  - downstream beat valid
//            out_ready  - downstream accepts beat
//            out        - one-hot result, OUT_W bits
//            out_err    - current beat carried an out-of-range code
//            err_cnt    - saturating count of accepted out-of-range beats
// Config   : ENC_B2OH_SKID_EN - when defined, a two-entry skid buffer makes
//            in_ready a register output; otherwise a single output register
//            with in_ready = !out_valid | out_ready.
// Revision : 1.0 - initial release
// ============================================================================
module enc_bin2onehot_stream
    import enc_b2oh_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [31:0]      w_code;
    logic [OUT_W-1:0] w_dec;
    logic             w_range_err;
    logic             w_accept;
    err_cnt_t         r_err_cnt;

    assign w_code      = 32'(in);
    assign w_range_err = (w_code >= 32'(OUT_W));

    // Out-of-range codes match no bit position and decode to all zeros.
    always_comb begin
        w_dec = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (w_code == 32'(k)) begin
                w_dec[k] = 1'b1;
            end
        end
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_range_err && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;

`ifdef ENC_B2OH_SKID_EN

    // Payload carries the error flag in the top bit alongside the one-hot word.
    logic [OUT_W:0] w_in_payload;
    logic [OUT_W:0] w_out_payload;

    assign w_in_payload = {w_range_err, w_dec};

    enc_b2oh_skid #(
        .DATA_W (OUT_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_payload),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_payload)
    );

    assign out     = w_out_payload[OUT_W-1:0];
    assign out_err = w_out_payload[OUT_W];

`else

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out;
    logic             r_out_err;

    // A beat may enter whenever the held beat leaves this cycle, which gives
    // full throughput at the cost of a combinational out_ready->in_ready path.
    assign in_ready = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
            r_out_err   <= w_range_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_err   = r_out_err;

`endif

endmodule : enc_bin2onehot_stream
`default_nettype wire

// File: tb/tb_enc_bin2onehot_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_bin2onehot_stream
// Purpose  : Self-checking bench for enc_bin2onehot_stream. Two instances are
//            exercised side by side: default widths (OUT_W=16) and OUT_W=12.
//            Expected behaviour comes from a queue model of held beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_bin2onehot_stream;

`ifdef ENC_B2OH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [15:0] oh;
        logic        err;
    } beat_t;

    logic        clk;
    logic        rst;

    logic        v16, r16, rdy16, ov16, e16;
    logic [3:0]  d16;
    logic [15:0] o16;
    logic [7:0]  c16;

    logic        v12, r12, rdy12, ov12, e12;
    logic [3:0]  d12;
    logic [11:0] o12;
    logic [7:0]  c12;

    beat_t       q16[$];
    beat_t       q12[$];
    int          cnt16;
    int          cnt12;

    int          errors;
    int          checks;

    enc_bin2onehot_stream u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .in_ready  (rdy16),
        .in        (d16),
        .out_valid (ov16),
        .out_ready (r16),
        .out       (o16),
        .out_err   (e16),
        .err_cnt   (c16)
    );

    enc_bin2onehot_stream #(
        .IN_W  (4),
        .OUT_W (12)
    ) u_dut12 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v12),
        .in_ready  (rdy12),
        .in        (d12),
        .out_valid (ov12),
        .out_ready (r12),
        .out       (o12),
        .out_err   (e12),
        .err_cnt   (c12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic beat_t ref_dec(input int code, input int ow);
        beat_t b;
        b.oh  = (code < ow) ? (16'(1) << code) : 16'h0000;
        b.err = (code >= ow);
        return b;
    endfunction

    // Without skid a slot frees when the held beat leaves; with skid ready
    // depends only on how many beats are held.
    function automatic logic mready(input int sz, input logic ordy);
        if (CAP == 2) return (sz < 2);
        return (sz == 0) || ordy;
    endfunction

    task automatic tick();
        logic a16, a12;
        a16 = v16 && mready(q16.size(), r16);
        a12 = v12 && mready(q12.size(), r12);
        @(posedge clk);
        if (r16 && q16.size() > 0) void'(q16.pop_front());
        if (r12 && q12.size() > 0) void'(q12.pop_front());
        if (a16) begin
            q16.push_back(ref_dec(int'(d16), 16));
            if (int'(d16) >= 16 && cnt16 < 255) cnt16++;
        end
        if (a12) begin
            q12.push_back(ref_dec(int'(d12), 12));
            if (int'(d12) >= 12 && cnt12 < 255) cnt12++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        v16 = 1'b0; d16 = 4'd0; r16 = 1'b1;
        v12 = 1'b0; d12 = 4'd0; r12 = 1'b1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4 && (q16.size() > 0 || q12.size() > 0); i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b0;
        #12;
        checks++;
        if (ov16 !== 1'b0 || o16 !== 16'h0 || e16 !== 1'b0 || c16 !== 8'd0) begin
            errors++;
            $display("FAIL reset16: valid=%b out=%h err=%b cnt=%0d required 0/0/0/0", ov16, o16, e16, c16);
        end
        checks++;
        if (ov12 !== 1'b0 || o12 !== 12'h0 || e12 !== 1'b0 || c12 !== 8'd0) begin
            errors++;
            $display("FAIL reset12: valid=%b out=%h err=%b cnt=%0d required 0/0/0/0", ov12, o12, e12, c12);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rdy16 !== 1'b1 || rdy12 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: rdy16=%b rdy12=%b required 1/1", rdy16, rdy12);
        end
    endtask

    task automatic test_decode_basic();
        v16 = 1'b1; d16 = 4'd5;  r16 = 1'b1;
        v12 = 1'b1; d12 = 4'd13; r12 = 1'b1;
        #1;
        checks++;
        if (c12 !== 8'd0) begin
            errors++;
            $display("FAIL basic_cnt_before: err_cnt=%0d required 0", c12);
        end
        tick();
        checks++;
        if (ov16 !== 1'b1 || o16 !== 16'h0020 || e16 !== 1'b0) begin
            errors++;
            $display("FAIL basic_in5: valid=%b out=%h err=%b required 1/0020/0", ov16, o16, e16);
        end
        checks++;
        if (ov12 !== 1'b1 || o12 !== 12'h000 || e12 !== 1'b1 || c12 !== 8'd1) begin
            errors++;
            $display("FAIL basic_in13: valid=%b out=%h err=%b cnt=%0d required 1/000/1/1", ov12, o12, e12, c12);
        end
        idle();
        tick();
        checks++;
        if (ov16 !== 1'b0 || ov12 !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: ov16=%b ov12=%b required 0/0", ov16, ov12);
        end
    endtask

    task automatic test_stall();
        int accepted, delivered;
        accepted = 0;
        delivered = 0;
        idle();
        r16 = 1'b0;
        v16 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d16 = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (rdy16 !== mready(q16.size(), 1'b0)) begin
                errors++;
                $display("FAIL stall_ready[%0d]: in_ready=%b required %b", i, rdy16, mready(q16.size(), 1'b0));
            end
            if (mready(q16.size(), 1'b0)) accepted++;
            tick();
            checks++;
            if (ov16 !== 1'b1 || o16 !== q16[0].oh || e16 !== q16[0].err) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b out=%h required 1/%h", i, ov16, o16, q16[0].oh);
            end
        end
        checks++;
        if (accepted != CAP || rdy16 !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: accepted=%0d in_ready=%b required %0d/0", accepted, rdy16, CAP);
        end
        v16 = 1'b0;
        r16 = 1'b1;
        for (int i = 0; i < 4 && q16.size() > 0; i++) begin
            checks++;
            if (ov16 !== 1'b1 || o16 !== q16[0].oh || e16 !== q16[0].err) begin
                errors++;
                $display("FAIL stall_release[%0d]: valid=%b out=%h required 1/%h", i, ov16, o16, q16[0].oh);
            end
            if (ov16 === 1'b1) delivered++;
            tick();
        end
        checks++;
        if (delivered != accepted || ov16 !== 1'b0) begin
            errors++;
            $display("FAIL stall_delivered: delivered=%0d valid=%b required %0d/0", delivered, ov16, accepted);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int i = 0; i < 16; i++) begin
            v16 = 1'b1; d16 = 4'(i); r16 = 1'b1;
            #1;
            checks++;
            if (rdy16 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, rdy16);
            end
            tick();
            checks++;
            if (ov16 !== 1'b1 || o16 !== (16'(1) << i) || e16 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_out[%0d]: valid=%b out=%h required 1/%h", i, ov16, o16, 16'(1) << i);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            v16 = 1'($urandom_range(0, 1)); d16 = 4'($urandom_range(0, 15));
            r16 = ($urandom_range(0, 3) != 0);
            v12 = 1'($urandom_range(0, 1)); d12 = 4'($urandom_range(0, 15));
            r12 = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (rdy16 !== mready(q16.size(), r16) || rdy12 !== mready(q12.size(), r12)) begin
                errors++;
                $display("FAIL rand_ready[%0d]: rdy16=%b rdy12=%b required %b/%b", n, rdy16, rdy12,
                         mready(q16.size(), r16), mready(q12.size(), r12));
            end
            checks++;
            if (ov16 !== (q16.size() > 0) || ov12 !== (q12.size() > 0)) begin
                errors++;
                $display("FAIL rand_valid[%0d]: ov16=%b ov12=%b required %0d/%0d", n, ov16, ov12,
                         q16.size() > 0, q12.size() > 0);
            end
            if (q16.size() > 0) begin
                checks++;
                if (o16 !== q16[0].oh || e16 !== q16[0].err) begin
                    errors++;
                    $display("FAIL rand_out16[%0d]: out=%h err=%b required %h/%b", n, o16, e16, q16[0].oh, q16[0].err);
                end
            end
            if (q12.size() > 0) begin
                checks++;
                if (o12 !== q12[0].oh[11:0] || e12 !== q12[0].err) begin
                    errors++;
                    $display("FAIL rand_out12[%0d]: out=%h err=%b required %h/%b", n, o12, e12, q12[0].oh[11:0], q12[0].err);
                end
            end
            checks++;
            if (c16 !== 8'(cnt16) || c12 !== 8'(cnt12)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: c16=%0d c12=%0d required %0d/%0d", n, c16, c12, cnt16, cnt12);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_saturate();
        idle();
        for (int n = 0; n < 300; n++) begin
            v12 = 1'b1;
            d12 = 4'(12 + $urandom_range(0, 3));
            tick();
            checks++;
            if (c12 !== 8'(cnt12) || ov12 !== 1'b1 || o12 !== 12'h000 || e12 !== 1'b1) begin
                errors++;
                $display("FAIL sat_step[%0d]: cnt=%0d valid=%b out=%h err=%b required %0d/1/000/1",
                         n, c12, ov12, o12, e12, cnt12);
            end
        end
        checks++;
        if (c12 !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: err_cnt=%0d required 255", c12);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        idle();
        v16 = 1'b1; d16 = 4'd3; r16 = 1'b0;
        v12 = 1'b1; d12 = 4'd14; r12 = 1'b0;
        tick();
        checks++;
        if (ov16 !== 1'b1 || ov12 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_loaded: ov16=%b ov12=%b required 1/1", ov16, ov12);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ov16 !== 1'b0 || o16 !== 16'h0 || c16 !== 8'd0 || ov12 !== 1'b0 || e12 !== 1'b0 || c12 !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_async: ov16=%b o16=%h c16=%0d ov12=%b e12=%b c12=%0d required all 0",
                     ov16, o16, c16, ov12, e12, c12);
        end
        q16.delete();
        q12.delete();
        cnt16 = 0;
        cnt12 = 0;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (rdy16 !== 1'b1 || rdy12 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: rdy16=%b rdy12=%b required 1/1", rdy16, rdy12);
        end
        tick();
        checks++;
        if (ov16 !== 1'b0 || ov12 !== 1'b0 || c12 !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_stale: ov16=%b ov12=%b c12=%0d required 0/0/0", ov16, ov12, c12);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cnt16  = 0;
        cnt12  = 0;
        rst    = 1'b0;
        idle();
        test_reset();
        test_decode_basic();
        test_stall();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_enc_bin2onehot_stream
`default_nettype wire
